fake_differential_serializer: RTL and testbench

FAKE_DIFFERENTIAL_SERIALIZER -- requirements
Module: fake_differential_serializer

---
 rtl/fake_differential_serializer.sv | 89 ++++++++
 tb/tb_fake_differential_serializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fake_differential_serializer.sv
// Parallel-to-serial lane driver: captures one word per channel every N bit
// clocks and emits registered pseudo-differential p/n lanes (SDR or DDR pairs).
module fake_differential_serializer #(
    parameter int                    C_channels = 4,
    parameter int                    C_bits     = 10,
    parameter bit                    C_ddr      = 1'b0,
    parameter logic [C_channels-1:0] C_invert   = '0
) (
    input  logic                              clk_shift,
    input  logic                              reset,
    input  logic [C_channels*C_bits-1:0]      in_data,
    input  logic                              enable,
    output logic                              load,
    output logic [C_channels*(C_ddr+1)-1:0]   out_p,
    output logic [C_channels*(C_ddr+1)-1:0]   out_n
);

    localparam int W     = C_ddr ? 2 : 1;
    localparam int N     = C_bits / W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int LANES = C_channels * W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    // A DDR lane pair must split the word evenly and a word needs at least two bits.
    generate
        if ((C_ddr && ((C_bits % 2) != 0)) || (C_bits < 2)) begin : g_bad_cfg
            $error("fake_differential_serializer: illegal C_bits/C_ddr combination");
        end
    endgenerate

    logic [CNT_W-1:0]  cnt;
    logic [C_bits-1:0] shreg [C_channels];
    logic              word_en;
    logic [LANES-1:0]  lane_next;
    logic [LANES-1:0]  out_p_q;

    // Free-running phase counter; load is decoded purely from its register.
    always_ff @(posedge clk_shift) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign load = (cnt == CNT_LAST);

    always_ff @(posedge clk_shift) begin
        if (reset) begin
            for (int k = 0; k < C_channels; k++) begin
                shreg[k] <= '0;
            end
            word_en <= 1'b0;
        end else if (load) begin
            for (int k = 0; k < C_channels; k++) begin
                shreg[k] <= in_data[k*C_bits +: C_bits];
            end
            word_en <= enable;
        end else begin
            for (int k = 0; k < C_channels; k++) begin
                shreg[k] <= shreg[k] >> W;
            end
        end
    end

    // The low W bits of each shift register are the bits due on the wire next.
    always_comb begin
        lane_next = '0;
        for (int k = 0; k < C_channels; k++) begin
            for (int b = 0; b < W; b++) begin
                lane_next[k*W+b] = word_en & (shreg[k][b] ^ C_invert[k]);
            end
        end
    end

    always_ff @(posedge clk_shift) begin
        if (reset) begin
            out_p_q <= '0;
        end else begin
            out_p_q <= lane_next;
        end
    end

    assign out_p = out_p_q;
    assign out_n = ~out_p_q;

endmodule

// File: tb/tb_fake_differential_serializer.sv
// Scoreboard bench for fake_differential_serializer: SDR, DDR and inverted-SDR
// instances share one stimulus stream and are checked against a word/slot model.
module tb_fake_differential_serializer;

    logic        clk_shift;
    logic        reset;
    logic [39:0] in_data;
    logic        enable;

    logic       load_s, load_d, load_i;
    logic [3:0] out_p_s, out_n_s, out_p_i, out_n_i;
    logic [7:0] out_p_d, out_n_d;

    fake_differential_serializer dut_sdr (
        .clk_shift (clk_shift),
        .reset     (reset),
        .in_data   (in_data),
        .enable    (enable),
        .load      (load_s),
        .out_p     (out_p_s),
        .out_n     (out_n_s)
    );

    fake_differential_serializer #(.C_ddr(1'b1)) dut_ddr (
        .clk_shift (clk_shift),
        .reset     (reset),
        .in_data   (in_data),
        .enable    (enable),
        .load      (load_d),
        .out_p     (out_p_d),
        .out_n     (out_n_d)
    );

    fake_differential_serializer #(.C_invert(4'b0001)) dut_inv (
        .clk_shift (clk_shift),
        .reset     (reset),
        .in_data   (in_data),
        .enable    (enable),
        .load      (load_i),
        .out_p     (out_p_i),
        .out_n     (out_n_i)
    );

    initial clk_shift = 1'b0;
    always #5 clk_shift = ~clk_shift;

    typedef struct packed {
        logic [2:0][7:0] p;
        logic [2:0]      ld;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Per-instance configuration: slots per word, bits per slot, inversion mask.
    int         cfg_n   [3] = '{10, 5, 10};
    int         cfg_w   [3] = '{1, 2, 1};
    logic [3:0] cfg_inv [3] = '{4'h0, 4'h0, 4'h1};
    logic [7:0] cfg_mask[3] = '{8'h0F, 8'hFF, 8'h0F};

    // Model state: non-reset edges since reset, slot of the word on the wire.
    int          m_edges [3] = '{0, 0, 0};
    int          m_slot  [3] = '{-1, -1, -1};
    logic [39:0] m_word  [3];
    logic        m_en    [3] = '{1'b0, 1'b0, 1'b0};

    function automatic logic [7:0] lanes(input int w, input logic [3:0] inv,
                                         input logic [39:0] data, input int slot);
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < w; b++) begin
                v[k*w+b] = data[k*10 + slot*w + b] ^ inv[k];
            end
        end
        return v;
    endfunction

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one cycle of inputs and pushes what each instance must show after the next edge.
    task automatic apply_stimulus(input logic rst, input logic [39:0] data, input logic en);
        exp_t e;
        @(negedge clk_shift);
        reset   = rst;
        in_data = data;
        enable  = en;
        e = '0;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_edges[d] = 0;
                m_slot[d]  = -1;
                e.p[d]     = 8'h00;
            end else begin
                m_edges[d]++;
                if (m_slot[d] >= 0 && m_en[d]) begin
                    e.p[d] = lanes(cfg_w[d], cfg_inv[d], m_word[d], m_slot[d]);
                end else begin
                    e.p[d] = 8'h00;
                end
                if (m_slot[d] >= 0) m_slot[d]++;
                if ((m_edges[d] % cfg_n[d]) == 0) begin
                    m_word[d] = data;
                    m_en[d]   = en;
                    m_slot[d] = 0;
                end
            end
            e.ld[d] = (((m_edges[d] + 1) % cfg_n[d]) == 0);
        end
        sb_q.push_back(e);
    endtask

    function automatic logic [39:0] with_ch0(input logic [9:0] word);
        logic [39:0] v;
        v = {$urandom(), $urandom()};
        v[9:0] = word;
        return v;
    endfunction

    // Monitor: one expected entry per clock edge, compared just after the edge.
    initial begin
        exp_t       e;
        logic [7:0] act_p [3];
        logic [7:0] act_n [3];
        logic       act_l [3];
        forever begin
            @(posedge clk_shift);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act_p[0] = {4'h0, out_p_s}; act_n[0] = {4'h0, out_n_s}; act_l[0] = load_s;
                act_p[1] = out_p_d;         act_n[1] = out_n_d;         act_l[1] = load_d;
                act_p[2] = {4'h0, out_p_i}; act_n[2] = {4'h0, out_n_i}; act_l[2] = load_i;
                for (int d = 0; d < 3; d++) begin
                    check_output($sformatf("out_p dut%0d", d), act_p[d], e.p[d]);
                    check_output($sformatf("out_n dut%0d", d), act_n[d], ~e.p[d] & cfg_mask[d]);
                    check_output($sformatf("load dut%0d", d), {7'h0, act_l[d]}, {7'h0, e.ld[d]});
                end
            end
        end
    end

    initial begin
        logic en_r;
        reset   = 1'b1;
        in_data = '0;
        enable  = 1'b0;

        repeat (3) apply_stimulus(1'b1, '0, 1'b0);

        // Held blue word, then the alternating DDR pattern, then all-ones for the inverted lane.
        repeat (25) apply_stimulus(1'b0, with_ch0(10'b1101001110), 1'b1);
        repeat (15) apply_stimulus(1'b0, with_ch0(10'h2AA), 1'b1);
        repeat (22) apply_stimulus(1'b0, with_ch0(10'h3FF), 1'b1);

        // Enable drops mid-word at phase 3: current word finishes, next one is idle.
        for (int i = 0; i < 20 && (m_edges[0] % 10) != 3; i++) begin
            apply_stimulus(1'b0, with_ch0(10'h1A5), 1'b1);
        end
        repeat (25) apply_stimulus(1'b0, with_ch0(10'h3FF), 1'b0);
        repeat (12) apply_stimulus(1'b0, with_ch0(10'h3C3), 1'b1);

        // Reset pulse at phase 6 aborts the word in flight.
        for (int i = 0; i < 20 && (m_edges[0] % 10) != 6; i++) begin
            apply_stimulus(1'b0, with_ch0(10'h3FF), 1'b1);
        end
        apply_stimulus(1'b1, with_ch0(10'h3FF), 1'b1);
        repeat (25) apply_stimulus(1'b0, with_ch0(10'h2D4), 1'b1);

        en_r = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) en_r = ~en_r;
            apply_stimulus(($urandom_range(79) == 0), {$urandom(), $urandom()}, en_r);
        end

        @(posedge clk_shift);
        #2;
        check_output("scoreboard drained", 8'(sb_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
